// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Purpose:
//   Valid/ready pipeline stage that registers a control bundle and a datapath
//   bundle between two pipeline stages. A flush discards every held beat and
//   any beat offered on the same edge. The control bundle of an empty stage
//   is always zero, so a bubble never carries a write-enable downstream.
//
// Build option:
//   PIPE_STAGE_SKID_EN  defined   -> main register + one skid register
//                                    (depth 2). in_ready comes straight from
//                                    a flop and has no path from out_ready.
//                       undefined -> single register (depth 1), with
//                                    in_ready = !out_valid || out_ready.
//
// Parameters:
//   CTRL_W      width of the control bundle (cleared on flush/reset)
//   DATA_W      width of the datapath bundle
//   DATA_CLEAR  1: datapath bundle zeroed on flush; 0: datapath retained on
//               flush. Reset always zeroes the datapath bundle.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   flush      in   discard held beats and this cycle's incoming beat
//   in_valid   in   upstream beat present
//   in_ready   out  stage can accept a beat this cycle
//   in_ctrl    in   upstream control bundle   [CTRL_W]
//   in_data    in   upstream datapath bundle  [DATA_W]
//   out_valid  out  beat presented downstream
//   out_ready  in   downstream accepts (0 = stall)
//   out_ctrl   out  registered control, zero whenever out_valid = 0
//   out_data   out  registered datapath bundle
//   occ        out  number of held beats (0..2)
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int CTRL_W     = 16,
    parameter int DATA_W     = 256,
    parameter int DATA_CLEAR = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ
);

`ifdef PIPE_STAGE_SKID_EN

    // Main register: the beat currently presented downstream.
    logic              main_vld_q,  main_vld_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;

    // Skid register: catches a beat accepted while main is stalled. It can
    // only be occupied when main is occupied.
    logic              skid_vld_q,  skid_vld_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    // Registered copy of "skid empty" so in_ready has no path from out_ready.
    logic              in_ready_q,  in_ready_d;

    logic              in_xfer;
    logic              out_xfer;

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = main_vld_q & out_ready;

    always_comb begin
        main_vld_d  = main_vld_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_vld_d  = skid_vld_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        if (flush) begin
            main_vld_d  = 1'b0;
            main_ctrl_d = '0;
            skid_vld_d  = 1'b0;
            skid_ctrl_d = '0;
            if (DATA_CLEAR != 0) begin
                main_data_d = '0;
                skid_data_d = '0;
            end
        end else if (out_xfer) begin
            if (skid_vld_q) begin
                // Promote the skid beat; in_ready_q was 0, so no new beat
                // can arrive on this edge.
                main_vld_d  = 1'b1;
                main_ctrl_d = skid_ctrl_q;
                main_data_d = skid_data_q;
                skid_vld_d  = 1'b0;
                skid_ctrl_d = '0;
            end else if (in_xfer) begin
                main_vld_d  = 1'b1;
                main_ctrl_d = in_ctrl;
                main_data_d = in_data;
            end else begin
                // Stage drains; clear ctrl so the bubble is harmless.
                main_vld_d  = 1'b0;
                main_ctrl_d = '0;
            end
        end else if (in_xfer) begin
            if (main_vld_q) begin
                skid_vld_d  = 1'b1;
                skid_ctrl_d = in_ctrl;
                skid_data_d = in_data;
            end else begin
                main_vld_d  = 1'b1;
                main_ctrl_d = in_ctrl;
                main_data_d = in_data;
            end
        end

        in_ready_d = ~skid_vld_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_vld_q  <= 1'b0;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_vld_q  <= 1'b0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            main_vld_q  <= main_vld_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_vld_q  <= skid_vld_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_vld_q;
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;
    // skid is only ever valid together with main: 00 -> 0, 01 -> 1, 11 -> 2.
    assign occ       = {main_vld_q & skid_vld_q, main_vld_q ^ skid_vld_q};

`else

    logic              vld_q,  vld_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic              in_xfer;
    logic              out_xfer;

    // Accept when empty or when the held beat leaves on this same edge.
    assign in_ready = ~vld_q | out_ready;
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = vld_q & out_ready;

    always_comb begin
        vld_d  = vld_q;
        ctrl_d = ctrl_q;
        data_d = data_q;

        if (flush) begin
            vld_d  = 1'b0;
            ctrl_d = '0;
            if (DATA_CLEAR != 0) begin
                data_d = '0;
            end
        end else if (in_xfer) begin
            vld_d  = 1'b1;
            ctrl_d = in_ctrl;
            data_d = in_data;
        end else if (out_xfer) begin
            vld_d  = 1'b0;
            ctrl_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            ctrl_q <= '0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            ctrl_q <= ctrl_d;
            data_q <= data_d;
        end
    end

    assign out_valid = vld_q;
    assign out_ctrl  = ctrl_q;
    assign out_data  = data_q;
    assign occ       = {1'b0, vld_q};

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a queue-based model of the stage is compared
// against two instances (DATA_CLEAR = 1 and DATA_CLEAR = 0) on every falling
// edge, alongside directed checks with literal expected values.
module tb_pipe_stage_reg;

    localparam int CW = 16;
    localparam int DW = 256;
`ifdef PIPE_STAGE_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_ready;

    logic          in_ready,  out_valid;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occ;

    logic          nc_in_ready, nc_out_valid;
    logic [CW-1:0] nc_out_ctrl;
    logic [DW-1:0] nc_out_data;
    logic [1:0]    nc_occ;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .DATA_CLEAR(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data), .occ(occ)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .DATA_CLEAR(0)) dut_nc (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(nc_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(nc_out_valid), .out_ready(out_ready),
        .out_ctrl(nc_out_ctrl), .out_data(nc_out_data), .occ(nc_occ)
    );

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model: a FIFO of at most DEPTH beats ----
    logic [CW-1:0] mq_c[$];
    logic [DW-1:0] mq_d[$];
    bit            mz = 1'b1;   // data of the DATA_CLEAR=1 stage known zero
    bit            m_ox, m_ix;

    function automatic bit model_rdy(input int n, input logic ordy);
        if (DEPTH == 2) return n < 2;
        return (n == 0) || (ordy == 1'b1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq_c.delete(); mq_d.delete(); mz = 1'b1;
        end else if (flush) begin
            mq_c.delete(); mq_d.delete(); mz = 1'b1;
        end else begin
            m_ox = (mq_c.size() > 0) && out_ready;
            m_ix = in_valid && model_rdy(mq_c.size(), out_ready);
            if (m_ox) begin
                void'(mq_c.pop_front());
                void'(mq_d.pop_front());
            end
            if (m_ix) begin
                mq_c.push_back(in_ctrl);
                mq_d.push_back(in_data);
                mz = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------------------------
    always @(negedge clk) begin
        if (mq_c.size() > 0) begin
            chk("m_valid",    DW'(out_valid),    DW'(1'b1));
            chk("m_ctrl",     DW'(out_ctrl),     DW'(mq_c[0]));
            chk("m_data",     out_data,          mq_d[0]);
            chk("m_nc_valid", DW'(nc_out_valid), DW'(1'b1));
            chk("m_nc_ctrl",  DW'(nc_out_ctrl),  DW'(mq_c[0]));
            chk("m_nc_data",  nc_out_data,       mq_d[0]);
        end else begin
            chk("m_valid",    DW'(out_valid),    '0);
            chk("m_ctrl",     DW'(out_ctrl),     '0);
            chk("m_nc_valid", DW'(nc_out_valid), '0);
            chk("m_nc_ctrl",  DW'(nc_out_ctrl),  '0);
            if (mz) chk("m_data_zero", out_data, '0);
        end
        chk("m_occ",      DW'(occ),         DW'(mq_c.size()));
        chk("m_nc_occ",   DW'(nc_occ),      DW'(mq_c.size()));
        chk("m_in_ready", DW'(in_ready),    DW'(model_rdy(mq_c.size(), out_ready)));
        chk("m_nc_rdy",   DW'(nc_in_ready), DW'(model_rdy(mq_c.size(), out_ready)));
    end

    task automatic cyc(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic r, input logic f);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0;
        in_data = '0; out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", DW'(out_valid), '0);
        chk("rst_occ",   DW'(occ),       '0);
        chk("rst_ctrl",  DW'(out_ctrl),  '0);
        chk("rst_data",  out_data,       '0);
        chk("rst_rdy",   DW'(in_ready),  DW'(1'b1));
        rst_n = 1'b1;
        chk("rel_rdy",   DW'(in_ready),  DW'(1'b1));

        // Single beat, latency 1
        cyc(1'b1, 16'h00A5, DW'(256'h1234), 1'b1, 1'b0);
        chk("one_valid", DW'(out_valid), DW'(1'b1));
        chk("one_ctrl",  DW'(out_ctrl),  DW'(16'h00A5));
        chk("one_data",  out_data,       DW'(256'h1234));
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        chk("one_after_valid", DW'(out_valid), '0);
        chk("one_after_ctrl",  DW'(out_ctrl),  '0);

        // Stream of 8 beats at full rate
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, CW'(i), DW'(i * 3), 1'b1, 1'b0);
            chk("stream_ctrl", DW'(out_ctrl), DW'(i));
            chk("stream_data", out_data,      DW'(i * 3));
            chk("stream_occ",  DW'(occ),      DW'(1));
        end
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        chk("stream_end", DW'(out_valid), '0);

        // Stall behaviour
        cyc(1'b1, CW'(1), DW'(256'h11), 1'b0, 1'b0);
        chk("stall_occ1", DW'(occ), DW'(1));
        cyc(1'b1, CW'(2), DW'(256'h22), 1'b0, 1'b0);
        if (DEPTH == 2) begin
            chk("skid_occ2",  DW'(occ),      DW'(2));
            chk("skid_rdy0",  DW'(in_ready), '0);
            chk("skid_hold1", DW'(out_ctrl), DW'(1));
            cyc(1'b0, '0, '0, 1'b0, 1'b0);
            chk("skid_hold2", DW'(out_ctrl), DW'(1));
            chk("skid_hdat",  out_data,      DW'(256'h11));
            cyc(1'b0, '0, '0, 1'b1, 1'b0);
            chk("skid_out2",  DW'(out_ctrl), DW'(2));
            chk("skid_rdy1",  DW'(in_ready), DW'(1'b1));
            chk("skid_occ_1", DW'(occ),      DW'(1));
            cyc(1'b0, '0, '0, 1'b1, 1'b0);
            chk("skid_empty", DW'(out_valid), '0);
        end else begin
            chk("d1_rdy0",    DW'(in_ready), '0);
            chk("d1_occ",     DW'(occ),      DW'(1));
            chk("d1_hold",    DW'(out_ctrl), DW'(1));
            cyc(1'b0, '0, '0, 1'b1, 1'b0);
            chk("d1_empty",   DW'(out_valid), '0);
        end

        // Flush overrides full stage plus coincident in/out transfers
        cyc(1'b1, CW'(3), DW'(256'h33), 1'b0, 1'b0);
        cyc(1'b1, CW'(4), DW'(256'h44), 1'b0, 1'b0);
        chk("pre_flush_occ", DW'(occ), DW'(DEPTH));
        cyc(1'b1, CW'(7), DW'(256'h77), 1'b1, 1'b1);
        chk("flush_occ",   DW'(occ),       '0);
        chk("flush_valid", DW'(out_valid), '0);
        chk("flush_ctrl",  DW'(out_ctrl),  '0);
        chk("flush_data",  out_data,       '0);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        chk("no_beat7", DW'(out_valid), '0);

        // DATA_CLEAR=0 retains datapath on flush
        cyc(1'b1, CW'(9), DW'(256'hBEEF), 1'b0, 1'b0);
        chk("nc_held", nc_out_data, DW'(256'hBEEF));
        cyc(1'b0, '0, '0, 1'b0, 1'b1);
        chk("nc_valid", DW'(nc_out_valid), '0);
        chk("nc_ctrl",  DW'(nc_out_ctrl),  '0);
        chk("nc_data",  nc_out_data,       DW'(256'hBEEF));
        chk("c_data",   out_data,          '0);

        // Asynchronous reset mid-cycle
        cyc(1'b1, CW'(5), DW'(256'h55), 1'b0, 1'b0);
        chk("pre_rst_occ", DW'(occ), DW'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", DW'(out_valid), '0);
        chk("arst_occ",   DW'(occ),       '0);
        chk("arst_rdy",   DW'(in_ready),  DW'(1'b1));
        chk("arst_ctrl",  DW'(out_ctrl),  '0);
        chk("arst_ncdat", nc_out_data,    '0);
        #2 rst_n = 1'b1;
        chk("post_rst_rdy", DW'(in_ready), DW'(1'b1));
        cyc(1'b1, CW'(6), DW'(256'h66), 1'b1, 1'b0);
        chk("post_rst_ctrl", DW'(out_ctrl), DW'(6));
        chk("post_rst_occ",  DW'(occ),      DW'(1));

        // Mixed valid/ready pattern with a flush in the middle
        for (int i = 0; i < 80; i++) begin
            cyc((i % 4) != 1, CW'(i + 16), DW'({32'(i), ~32'(i)}),
                (i % 3) != 0, i == 40);
        end
        repeat (3) cyc(1'b0, '0, '0, 1'b1, 1'b0);
        chk("drain_occ",   DW'(occ),       '0);
        chk("drain_valid", DW'(out_valid), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter CTRL_W, default 16: width of control bundle (write-enables, selects, ALU op); zeroed on flush/reset.
REQ-002 SHALL have parameter DATA_W, default 256: width of datapath bundle (PC, immediate, PC+4, operands, register indices).
REQ-003 SHALL have parameter DATA_CLEAR, default 1: 1 = data bundle zeroed on flush/reset; 0 = data bundle retains value, only valid/ctrl cleared.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 flush  input  1  discard all held beats and any beat presented this cycle.
REQ-007 in_valid  input  1  upstream beat present.
REQ-008 in_ready  output  1  stage can accept a beat this cycle.
REQ-009 in_ctrl  input  CTRL_W  upstream control bundle.
REQ-010 in_data  input  DATA_W  upstream datapath bundle.
REQ-011 out_valid  output  1  beat presented downstream.
REQ-012 out_ready  input  1  downstream accepts (0 = stall).
REQ-013 out_ctrl  output  CTRL_W  registered control; all-zero whenever out_valid=0.
REQ-014 out_data  output  DATA_W  registered datapath bundle.
REQ-015 occ  output  2  number of held beats (0..2).

Function
REQ-016 Input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; output transfer on a rising edge with out_valid=1 and out_ready=1.
REQ-017 Latency SHALL be exactly 1 cycle from input transfer to out_valid=1 when the stage is empty.
REQ-018 Beats SHALL leave in acceptance order; no beat duplicated or lost except by flush.
REQ-019 While out_valid=1 and out_ready=0, out_ctrl/out_data/out_valid SHALL hold stable.
REQ-020 flush=1 on an edge SHALL set occ=0, out_valid=0, out_ctrl=0, out_data=0 if DATA_CLEAR=1, and discard any beat transferred that edge; flush SHALL override simultaneous input and output transfers.
REQ-021 in_ready SHALL NOT depend on flush.
REQ-022 Simultaneous input and output transfer (no flush) SHALL leave occ unchanged and present the next beat the following cycle.
REQ-023 occ SHALL equal the number of beats held after each edge; never exceeds the configured depth (1 or 2).
REQ-024 out_ctrl SHALL be forced all-zero whenever out_valid=0, so a bubble never carries a write-enable.

Reset
REQ-025 rst_n=0 SHALL asynchronously set out_valid=0, occ=0, out_ctrl=0, out_data=0 (regardless of DATA_CLEAR), and skid entry empty.
REQ-026 Reset asserted mid-transfer SHALL drop all held beats; the first edge after rst_n rises SHALL behave as empty stage.
REQ-027 in_ready SHALL be 1 while in reset and on the first cycle after reset release.

Configuration
REQ-028 Macro PIPE_STAGE_SKID_EN SHALL select buffering depth.
REQ-029 With PIPE_STAGE_SKID_EN defined: main register plus one skid register (depth 2); in_ready SHALL be driven directly from a flop (= skid entry empty), with no combinational path from out_ready; sustained 1 beat/cycle throughput; a beat arriving while main is stalled SHALL be captured in skid and promoted to main on the next output transfer.
REQ-030 Without PIPE_STAGE_SKID_EN: single register (depth 1), no skid storage; in_ready = !out_valid || out_ready (combinational); occ limited to 0..1; full throughput when out_ready=1.

Verification
REQ-031 Reset, then in_valid=1, in_ctrl=16'h00A5, in_data=256'h1234 for one cycle, out_ready=1 -> next cycle out_valid=1, out_ctrl=16'h00A5, out_data=256'h1234; following cycle out_valid=0, out_ctrl=0.
REQ-032 Stream 8 beats with ctrl=1..8, out_ready=1 -> 8 consecutive outputs ctrl=1..8, one per cycle, occ=1 throughout.
REQ-033 SKID build: out_ready=0, send beats ctrl=1,2 -> occ=2, in_ready=0, out_ctrl=1 held; raise out_ready -> outputs ctrl=1 then 2, in_ready=1 one cycle after first output transfer.
REQ-034 occ=2, flush=1 coincident with in_valid=1 ctrl=7 and out_ready=1 -> next cycle occ=0, out_valid=0, out_ctrl=0, out_data=0 (DATA_CLEAR=1); beat 7 never appears.
REQ-035 DATA_CLEAR=0, out_data=256'hBEEF held, flush=1 -> out_valid=0, out_ctrl=0, out_data=256'hBEEF.
REQ-036 occ=1, out_ready=0, rst_n pulsed low mid-cycle -> out_valid=0, occ=0 immediately without clock edge; in_ready=1.
